// File: rtl/blinker_pkg.sv
// Shared types and defaults for the multi-channel LED blinker.
package blinker_pkg;

    typedef enum logic [1:0] {
        BLINK_OFF     = 2'd0,
        BLINK_ON      = 2'd1,
        BLINK_RUN     = 2'd2,
        BLINK_RUN_INV = 2'd3
    } mode_e;

    localparam int DEFAULT_TICKS_PER_MS = 50000;

endpackage

// File: rtl/blink_channel.sv
// One LED channel: holds its own period/duty/mode and a millisecond phase counter.
module blink_channel
    import blinker_pkg::*;
#(
    parameter int PERIOD_W = 14,
    parameter int DUTY_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ms_tick,
    input  logic                clear,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic [DUTY_W-1:0]   duty_in,
    input  mode_e               mode_in,
    output logic                led
);

    localparam int FULL_W = PERIOD_W + DUTY_W + 1;

    logic [PERIOD_W-1:0] period_r;
    logic [PERIOD_W-1:0] cnt_r;
    logic [DUTY_W-1:0]   duty_r;
    mode_e               mode_r;
    logic [FULL_W-1:0]   phase_s;
    logic [FULL_W-1:0]   thresh_s;
    logic                blink_s;

    // Configuration and phase counter; a load wins over a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_r <= PERIOD_W'(1'b1);
            duty_r   <= DUTY_W'(1'b1);
            mode_r   <= BLINK_RUN;
            cnt_r    <= '0;
        end else if (load) begin
            period_r <= period_in;
            duty_r   <= duty_in;
            mode_r   <= mode_in;
            cnt_r    <= '0;
        end else if (clear) begin
            cnt_r    <= '0;
        end else if (ms_tick) begin
            if (cnt_r >= period_r) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + PERIOD_W'(1'b1);
            end
        end
    end

    // Duty compare kept one bit wider than the product so nothing is truncated.
    always_comb begin
        phase_s  = {1'b0, cnt_r, {DUTY_W{1'b0}}};
        thresh_s = FULL_W'(duty_r) * (FULL_W'(period_r) + FULL_W'(1'b1));
        blink_s  = (phase_s < thresh_s);
    end

    // Mode select for the LED drive.
    always_comb begin
        led = 1'b0;
        case (mode_r)
            BLINK_OFF:     led = 1'b0;
            BLINK_ON:      led = 1'b1;
            BLINK_RUN:     led = blink_s;
            BLINK_RUN_INV: led = ~blink_s;
            default:       led = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_led_blinker.sv
// Multi-channel LED blinker top: key synchroniser, ms prescaler, channel select.
// Define MULTI_LED_BLINKER_SYNC_EN to make every valid load restart all channels in phase.
module multi_led_blinker
    import blinker_pkg::*;
#(
    parameter int  CHANNELS     = 4,
    parameter int  PERIOD_W     = 14,
    parameter int  DUTY_W       = 2,
    parameter int  TICKS_PER_MS = DEFAULT_TICKS_PER_MS,
    localparam int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_n,
    input  logic [SEL_W-1:0]    sel,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic [DUTY_W-1:0]   duty_in,
    input  logic [1:0]          mode_in,
    output logic [CHANNELS-1:0] led
);

    localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICKS_PER_MS - 1);
    localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(CHANNELS);

    logic                s1_r;
    logic                s2_r;
    logic                s3_r;
    logic [PRE_W-1:0]    pre_r;
    logic                load_s;
    logic                sel_valid_s;
    logic                clear_all_s;
    logic                ms_tick_s;
    logic [CHANNELS-1:0] ch_load_s;

    // Three-flop key synchroniser; reset high so a held key cannot fake an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b1;
            s2_r <= 1'b1;
            s3_r <= 1'b1;
        end else begin
            s1_r <= key_n;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Falling-edge detect, select decode and optional global phase clear.
    always_comb begin
        ch_load_s   = '0;
        load_s      = s3_r & ~s2_r;
        sel_valid_s = ({1'b0, sel} < SEL_LIMIT);
        ms_tick_s   = (pre_r == PRE_LAST);
`ifdef MULTI_LED_BLINKER_SYNC_EN
        clear_all_s = load_s & sel_valid_s;
`else
        clear_all_s = 1'b0;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            ch_load_s[i] = load_s & sel_valid_s & ({1'b0, sel} == (SEL_W + 1)'(i));
        end
    end

    // Shared millisecond prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r <= '0;
        end else if (clear_all_s || ms_tick_s) begin
            pre_r <= '0;
        end else begin
            pre_r <= pre_r + PRE_W'(1'b1);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        blink_channel #(
            .PERIOD_W (PERIOD_W),
            .DUTY_W   (DUTY_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .ms_tick   (ms_tick_s),
            .clear     (clear_all_s),
            .load      (ch_load_s[g]),
            .period_in (period_in),
            .duty_in   (duty_in),
            .mode_in   (mode_e'(mode_in)),
            .led       (led[g])
        );
    end

endmodule

// File: tb/tb_multi_led_blinker.sv
// Scoreboard bench for multi_led_blinker: stimulus queues per-cycle LED expectations,
// a negedge monitor pops and compares them.
module tb_multi_led_blinker;
    import blinker_pkg::*;

    localparam int CH = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_n = 1'b1;
    logic [2:0]    sel = 3'd0;
    logic [13:0]   period_in = 14'd0;
    logic [1:0]    duty_in = 2'd0;
    logic [1:0]    mode_in = 2'd0;
    logic [CH-1:0] led;

    always #5 clk = ~clk;

    multi_led_blinker #(
        .CHANNELS     (CH),
        .PERIOD_W     (14),
        .DUTY_W       (2),
        .TICKS_PER_MS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .sel       (sel),
        .period_in (period_in),
        .duty_in   (duty_in),
        .mode_in   (mode_in),
        .led       (led)
    );

    // Clock edges since reset release.
    int unsigned cyc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int unsigned   cyc;
        logic [CH-1:0] val;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Per-channel expected waveform: kind 0 = const 0, 1 = const 1, 2 = periodic.
    int          kind [CH];
    int unsigned base [CH];
    int unsigned hi   [CH];
    int unsigned tot  [CH];
    bit          inv  [CH];

    // Monitor: compare the LED bank against the queued expectation for this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            mon_e = sb_q.pop_front();
            total++;
            bad++;
            $display("FAIL missed cyc=%0d now=%0d", mon_e.cyc, cyc);
        end
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            mon_e = sb_q.pop_front();
            total++;
            if (led !== mon_e.val) begin
                bad++;
                $display("FAIL led cyc=%0d got=%b want=%b", cyc, led, mon_e.val);
            end
        end
    end

    function automatic logic exp_bit(int ch, int unsigned c);
        logic b;
        if (kind[ch] == 0)      b = 1'b0;
        else if (kind[ch] == 1) b = 1'b1;
        else                    b = (((c - base[ch]) % tot[ch]) < hi[ch]) ? ~inv[ch] : inv[ch];
        return b;
    endfunction

    task automatic set_default();
        for (int i = 0; i < CH; i++) begin
            kind[i] = 2; base[i] = 0; hi[i] = 4; tot[i] = 8; inv[i] = 1'b0;
        end
    endtask

    task automatic set_wave(int ch, int unsigned b, int unsigned h, int unsigned t, bit iv);
        kind[ch] = 2; base[ch] = b; hi[ch] = h; tot[ch] = t; inv[ch] = iv;
    endtask

    task automatic push_span(int unsigned a, int unsigned b);
        exp_t e;
        for (int unsigned c = a; c <= b; c++) begin
            e.cyc = c;
            for (int i = 0; i < CH; i++) e.val[i] = exp_bit(i, c);
            sb_q.push_back(e);
        end
    endtask

    // A valid load in the phase-aligned build restarts every periodic channel at b.
    task automatic apply_sync(int unsigned b);
`ifdef MULTI_LED_BLINKER_SYNC_EN
        for (int i = 0; i < CH; i++) if (kind[i] == 2) base[i] = b;
`else
        if (b == 0) $display("note: load at cycle 0");
`endif
    endtask

    // Press the key so the load edge lands on a ms boundary; returns that edge's cycle.
    task automatic press(input logic [2:0] s, input logic [13:0] p, input logic [1:0] d,
                         input logic [1:0] m, output int unsigned b);
        @(negedge clk);
        while (cyc % 4 != 1) @(negedge clk);
        key_n = 1'b0; sel = s; period_in = p; duty_in = d; mode_in = m;
        b = cyc + 3;
        push_span(cyc + 1, b - 1);
    endtask

    task automatic release_key();
        repeat (3) @(negedge clk);
        period_in = 14'h3fff; duty_in = 2'd0; mode_in = 2'd1; sel = 3'd0;
        @(negedge clk);
        key_n = 1'b1;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() > 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain timeout left=%0d want=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b;
        exp_t e;
        set_default();

        // Reset state: all LEDs on, then default 4-on/4-off blink.
        e.cyc = 0; e.val = '1; sb_q.push_back(e);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push_span(1, 24);
        drain();

        // ch2: period 3, duty 2 -> 8 high, 8 low from the load edge.
        press(3'd2, 14'd3, 2'd2, 2'd2, b);
        apply_sync(b);
        set_wave(2, b, 8, 16, 1'b0);
        push_span(b, b + 40);
        release_key();
        drain();

        // ch1 OFF, then BLINK_INV period 1 duty 1 -> 4 low, 4 high.
        press(3'd1, 14'd5, 2'd3, 2'd0, b);
        apply_sync(b);
        kind[1] = 0;
        push_span(b, b + 20);
        release_key();
        drain();
        press(3'd1, 14'd1, 2'd1, 2'd3, b);
        apply_sync(b);
        set_wave(1, b, 4, 8, 1'b1);
        push_span(b, b + 24);
        release_key();
        drain();

        // ch3 with key held 100 clk while period_in churns: one load, value 3 captured.
        press(3'd3, 14'd3, 2'd2, 2'd2, b);
        apply_sync(b);
        set_wave(3, b, 8, 16, 1'b0);
        push_span(b, b + 100);
        for (int k = 0; k < 100; k++) begin
            period_in = (k == 2) ? 14'd3 : 14'd200 + 14'(k);
            @(negedge clk);
        end
        key_n = 1'b1;
        drain();

        // Out-of-range select: nothing changes.
        press(3'd5, 14'd0, 2'd0, 2'd1, b);
        push_span(b, b + 40);
        release_key();
        drain();
        press(3'd7, 14'd0, 2'd0, 2'd0, b);
        push_span(b, b + 24);
        release_key();
        drain();

        // Reset inside the synchroniser window cancels the pending load.
        @(negedge clk);
        key_n = 1'b0; sel = 3'd2; period_in = 14'd7; mode_in = 2'd1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        e.cyc = 0; e.val = '1; sb_q.push_back(e);
        repeat (2) @(negedge clk);
        key_n = 1'b1;
        set_default();
        rst = 1'b0;
        push_span(1, 32);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
